// File: rtl/mux_arb_2to1.sv
// Wormhole packet arbiter for the 2:1 router output mux: locks the output to one port from
// HEAD to TAIL, round-robin between packets, and counts completed packets.
module mux_arb_2to1 #(
    parameter int unsigned DATAW     = 67,
    parameter int unsigned TYPEW     = 3,
    parameter int unsigned TYPE_NONE = 0,
    parameter int unsigned TYPE_HEAD = 1,
    parameter int unsigned TYPE_TAIL = 2,
    parameter int unsigned TYPE_DATA = 3,
    parameter int unsigned SELW      = 5,
    parameter int unsigned CNTW      = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata_0,
    input  logic             ivalid_0,
    input  logic [DATAW-1:0] idata_1,
    input  logic             ivalid_1,
    input  logic             ordy,
    output logic [SELW-1:0]  sel,
    output logic             grant_0,
    output logic             grant_1,
    output logic             busy,
    output logic [CNTW-1:0]  pkt_cnt
);

    localparam logic [TYPEW-1:0] HeadCode = TYPEW'(TYPE_HEAD);
    localparam logic [TYPEW-1:0] TailCode = TYPEW'(TYPE_TAIL);
    localparam logic [TYPEW-1:0] NoneCode = TYPEW'(TYPE_NONE);
    localparam logic [TYPEW-1:0] DataCode = TYPEW'(TYPE_DATA);

    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [TYPEW-1:0] ftype_0, ftype_1;
    logic             req_0, req_1;
    logic             tail_0, tail_1;

    assign ftype_0 = idata_0[DATAW-1:DATAW-TYPEW];
    assign ftype_1 = idata_1[DATAW-1:DATAW-TYPEW];
    assign req_0   = ivalid_0 && (ftype_0 == HeadCode);
    assign req_1   = ivalid_1 && (ftype_1 == HeadCode);
    assign tail_0  = ftype_0 == TailCode;
    assign tail_1  = ftype_1 == TailCode;

    // Only the type field matters; payload bits and the NONE/DATA codes are don't-cares here.
    logic unused_bits;
    assign unused_bits = ^{idata_0[DATAW-TYPEW-1:0], idata_1[DATAW-TYPEW-1:0],
                           ftype_0 == NoneCode, ftype_1 == DataCode};

    // sel decodes the state register only, so ordy never reaches it combinationally.
    always_comb begin
        sel = '0;
        unique case (state_q)
            StLock0: sel[0] = 1'b1;
            StLock1: sel[1] = 1'b1;
            default: sel    = '0;
        endcase
    end

    assign grant_0 = sel[0] && ordy && ivalid_0;
    assign grant_1 = sel[1] && ordy && ivalid_1;
    assign busy    = state_q != StIdle;
    assign pkt_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_0 && req_1) begin
                    state_d = ptr_q ? StLock1 : StLock0;
                end else if (req_0) begin
                    state_d = StLock0;
                end else if (req_1) begin
                    state_d = StLock1;
                end
            end
            StLock0: begin
                if (grant_0 && tail_0) begin
                    state_d = StIdle;
                    ptr_d   = 1'b1;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            StLock1: begin
                if (grant_1 && tail_1) begin
                    state_d = StIdle;
                    ptr_d   = 1'b0;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Directed bench for mux_arb_2to1: inputs change just after the falling edge, outputs are
// checked 1 time unit later, well away from the rising edge.
module tb_mux_arb_2to1;

    localparam int unsigned DATAW = 67;
    localparam int unsigned TYPEW = 3;
    localparam logic [2:0] TN = 3'd0;
    localparam logic [2:0] TH = 3'd1;
    localparam logic [2:0] TT = 3'd2;
    localparam logic [2:0] TD = 3'd3;

    logic             clk = 1'b0;
    logic             rst_;
    logic [DATAW-1:0] idata_0, idata_1;
    logic             ivalid_0, ivalid_1, ordy;
    logic [4:0]       sel;
    logic             grant_0, grant_1, busy;
    logic [15:0]      pkt_cnt;

    int n_pass = 0;
    int n_total = 0;
    int granted;
    int k;

    mux_arb_2to1 dut (
        .clk     (clk),
        .rst_    (rst_),
        .idata_0 (idata_0),
        .ivalid_0(ivalid_0),
        .idata_1 (idata_1),
        .ivalid_1(ivalid_1),
        .ordy    (ordy),
        .sel     (sel),
        .grant_0 (grant_0),
        .grant_1 (grant_1),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drv(input logic v0, input logic [2:0] t0, input logic v1,
                       input logic [2:0] t1, input logic ro);
        idata_0  = {t0, 32'($urandom), 32'($urandom)};
        idata_1  = {t1, 32'($urandom), 32'($urandom)};
        ivalid_0 = v0;
        ivalid_1 = v1;
        ordy     = ro;
        #1;
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    initial begin
        // Reset with random traffic on both ports
        rst_ = 1'b0;
        drv(1'b1, TH, 1'b1, TH, 1'b1);
        @(negedge clk);
        drv(1'b1, TT, 1'b1, TH, 1'b1);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_g0", 32'(grant_0), 32'd0);
        chk("rst_g1", 32'(grant_1), 32'd0);
        chk("rst_cnt", 32'(pkt_cnt), 32'd0);
        #4;
        drv(1'b0, TN, 1'b0, TN, 1'b1);
        rst_ = 1'b1;
        nxt();
        nxt();
        drv(1'b0, TN, 1'b0, TN, 1'b1);
        chk("idle_sel", 32'(sel), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single packet on port 1: HEAD + 20 DATA + TAIL
        granted = 0;
        drv(1'b0, TN, 1'b1, TH, 1'b1);
        chk("p1_pre_sel", 32'(sel), 32'd0);
        chk("p1_pre_g1", 32'(grant_1), 32'd0);
        nxt();
        drv(1'b0, TN, 1'b1, TH, 1'b1);
        chk("p1_sel", 32'(sel), 32'd2);
        chk("p1_busy", 32'(busy), 32'd1);
        if (grant_1) granted++;
        nxt();
        for (int i = 0; i < 20; i++) begin
            drv(1'b0, TN, 1'b1, TD, 1'b1);
            if (grant_1) granted++;
            nxt();
        end
        drv(1'b0, TN, 1'b1, TT, 1'b1);
        chk("p1_tail_g1", 32'(grant_1), 32'd1);
        if (grant_1) granted++;
        nxt();
        drv(1'b0, TN, 1'b0, TN, 1'b1);
        chk("p1_rel_sel", 32'(sel), 32'd0);
        chk("p1_rel_busy", 32'(busy), 32'd0);
        chk("p1_cnt", 32'(pkt_cnt), 32'd1);
        chk("p1_granted", 32'(granted), 32'd22);

        // Tie: pointer is back at port 0
        drv(1'b1, TH, 1'b1, TH, 1'b1);
        chk("tie_pre_sel", 32'(sel), 32'd0);
        nxt();
        drv(1'b1, TH, 1'b1, TH, 1'b1);
        chk("tie_sel", 32'(sel), 32'd1);
        chk("tie_g0", 32'(grant_0), 32'd1);
        chk("tie_g1", 32'(grant_1), 32'd0);
        nxt();
        drv(1'b1, TD, 1'b1, TH, 1'b1);
        chk("tie_data_g1", 32'(grant_1), 32'd0);
        nxt();
        drv(1'b1, TT, 1'b1, TH, 1'b1);
        chk("tie_tail_g0", 32'(grant_0), 32'd1);
        nxt();
        drv(1'b0, TN, 1'b1, TH, 1'b1);
        chk("gap_sel", 32'(sel), 32'd0);
        chk("gap_g1", 32'(grant_1), 32'd0);
        chk("gap_cnt", 32'(pkt_cnt), 32'd2);
        nxt();
        drv(1'b0, TN, 1'b1, TH, 1'b1);
        chk("rr_sel", 32'(sel), 32'd2);
        chk("rr_g1", 32'(grant_1), 32'd1);
        nxt();
        // HEAD on the locked port is just a flit; port 0 waits
        drv(1'b1, TH, 1'b1, TH, 1'b1);
        chk("lk_head_sel", 32'(sel), 32'd2);
        chk("lk_head_g1", 32'(grant_1), 32'd1);
        nxt();
        drv(1'b1, TH, 1'b1, TT, 1'b1);
        chk("rr_tail_g0", 32'(grant_0), 32'd0);
        chk("rr_tail_g1", 32'(grant_1), 32'd1);
        nxt();
        drv(1'b1, TH, 1'b1, TH, 1'b1);
        chk("tie2_gap_sel", 32'(sel), 32'd0);
        chk("tie2_cnt", 32'(pkt_cnt), 32'd3);
        nxt();
        drv(1'b1, TT, 1'b1, TH, 1'b1);
        chk("tie2_sel", 32'(sel), 32'd1);
        chk("tie2_g0", 32'(grant_0), 32'd1);
        nxt();
        drv(1'b0, TN, 1'b0, TN, 1'b1);
        chk("tie2_rel_sel", 32'(sel), 32'd0);
        chk("tie2_cnt2", 32'(pkt_cnt), 32'd4);
        nxt();

        // Back-pressure: port 0 packet with ordy low for 3 cycles mid-packet
        granted = 0;
        k = 0;
        for (int c = 0; c < 40 && k < 22; c++) begin
            logic ro;
            logic [2:0] ty;
            ro = !(c >= 8 && c < 11);
            ty = (k == 0) ? TH : (k == 21) ? TT : TD;
            drv(1'b1, ty, 1'b0, TN, ro);
            if (!ro) begin
                chk("bp_g0", 32'(grant_0), 32'd0);
                chk("bp_sel", 32'(sel), 32'd1);
                chk("bp_busy", 32'(busy), 32'd1);
            end
            if (grant_0) begin
                k++;
                granted++;
            end
            nxt();
        end
        drv(1'b0, TN, 1'b0, TN, 1'b1);
        chk("bp_granted", 32'(granted), 32'd22);
        chk("bp_rel_sel", 32'(sel), 32'd0);
        chk("bp_cnt", 32'(pkt_cnt), 32'd5);
        nxt();

        // Non-HEAD flit on idle port 0 is ignored
        drv(1'b1, TD, 1'b0, TN, 1'b1);
        chk("nh_g0", 32'(grant_0), 32'd0);
        nxt();
        drv(1'b1, TD, 1'b0, TN, 1'b1);
        chk("nh_sel", 32'(sel), 32'd0);
        chk("nh_busy", 32'(busy), 32'd0);
        nxt();

        // Mid-packet reset on port 1 after 5 DATA
        drv(1'b0, TN, 1'b1, TH, 1'b1);
        nxt();
        drv(1'b0, TN, 1'b1, TH, 1'b1);
        chk("mr_sel", 32'(sel), 32'd2);
        nxt();
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, TN, 1'b1, TD, 1'b1);
            nxt();
        end
        drv(1'b0, TN, 1'b1, TD, 1'b1);
        rst_ = 1'b0;
        #1;
        chk("mr_rst_sel", 32'(sel), 32'd0);
        chk("mr_rst_busy", 32'(busy), 32'd0);
        chk("mr_rst_g1", 32'(grant_1), 32'd0);
        chk("mr_rst_cnt", 32'(pkt_cnt), 32'd0);
        nxt();
        rst_ = 1'b1;
        drv(1'b0, TN, 1'b1, TH, 1'b1);
        chk("mr_new_pre", 32'(sel), 32'd0);
        nxt();
        drv(1'b0, TN, 1'b1, TT, 1'b1);
        chk("mr_new_sel", 32'(sel), 32'd2);
        chk("mr_new_g1", 32'(grant_1), 32'd1);
        nxt();
        drv(1'b0, TN, 1'b0, TN, 1'b1);
        chk("mr_new_rel", 32'(sel), 32'd0);
        chk("mr_new_cnt", 32'(pkt_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
